// File: rtl/bcd_pkg.sv
// Shared types, default widths and the add-3 digit helper for the BCD conversion scheduler.
package bcd_pkg;

  localparam int unsigned DefNReq   = 4;
  localparam int unsigned DefDataW  = 16;
  localparam int unsigned DefDigits = 5;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StConvert = 2'd1,
    StDone    = 2'd2
  } state_e;

  function automatic logic [3:0] digit_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_dabble_engine.sv
// Shift/add-3 datapath: one double-dabble iteration per cycle while run is high.
module bcd_dabble_engine
  import bcd_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DIGITS = DefDigits,
  parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  run,
  input  logic [DATA_W-1:0]     operand,
  output logic                  last,
  output logic [DIGITS*4-1:0]   digits
);

  logic [DIGITS*4-1:0] bcd_q, bcd_adj, bcd_nx;
  logic [DATA_W-1:0]   opnd_q, opnd_nx;
  logic [CNT_W-1:0]    cnt_q;

  always_comb begin
    bcd_adj = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      bcd_adj[d*4 +: 4] = digit_adjust(bcd_q[d*4 +: 4]);
    end
    {bcd_nx, opnd_nx} = {bcd_adj, opnd_q} << 1;
  end

  // digits is the post-iteration value so the owner can capture it on the final edge.
  assign digits = bcd_nx;
  assign last   = run && (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      bcd_q  <= '0;
      opnd_q <= operand;
      cnt_q  <= '0;
    end else if (run) begin
      bcd_q  <= bcd_nx;
      opnd_q <= opnd_nx;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Round-robin arbiter sharing one binary-to-BCD engine among N_REQ requesters.
module bcd_convert_scheduler
  import bcd_pkg::*;
#(
  parameter int unsigned N_REQ  = DefNReq,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DIGITS = DefDigits,
  parameter int unsigned ID_W   = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   number,
  output logic [N_REQ-1:0]          ack,
  output logic                      busy,
  output logic                      done,
  output logic [ID_W-1:0]           done_id,
  output logic [DIGITS*4-1:0]       bcd_number
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  state_e              state;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     winner;
  logic                found;
  logic                eng_load, eng_run, eng_last;
  logic [DATA_W-1:0]   operand;
  logic [DIGITS*4-1:0] eng_digits;

  // Search starts just past the previous grant so it naturally gets lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      int unsigned idx;
      idx = (32'(last_grant) + 1 + i) % N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign operand  = number[winner*DATA_W +: DATA_W];
  assign eng_load = (state == StIdle) && found;
  assign eng_run  = (state == StConvert);

  bcd_dabble_engine #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS),
    .CNT_W  (CntW)
  ) u_engine (
    .clk     (clk),
    .reset   (reset),
    .load    (eng_load),
    .run     (eng_run),
    .operand (operand),
    .last    (eng_last),
    .digits  (eng_digits)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= StIdle;
      last_grant <= ID_W'(N_REQ - 1);
      ack        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= '0;
      bcd_number <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          ack <= '0;
          if (found) begin
            state       <= StConvert;
            busy        <= 1'b1;
            last_grant  <= winner;
            ack[winner] <= 1'b1;
          end
        end
        StConvert: begin
          ack <= '0;
          if (eng_last) begin
            state      <= StDone;
            done       <= 1'b1;
            done_id    <= last_grant;
            bcd_number <= eng_digits;
          end
        end
        StDone: begin
          state <= StIdle;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= StIdle;
          ack   <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
